// File: rtl/instr_register_pkg.sv
// -----------------------------------------------------------------------------
// instr_register_pkg
// Shared types for the instruction register and its write/read scheduler.
//   opcode_t       : instruction opcode
//   operand_t      : signed 32-bit operand
//   address_t      : instruction-register address (sets the maximum depth)
//   instruction_t  : opcode plus both operands, as held in one entry
//   irs_state_t    : scheduler FSM state (INIT while the register is held in
//                    reset, RUN once traffic may flow)
// -----------------------------------------------------------------------------
package instr_register_pkg;

   typedef enum logic [3:0] {
      ZERO,
      PASSA,
      PASSB,
      ADD,
      SUB,
      MULT,
      DIV,
      MOD
   } opcode_t;

   typedef logic signed [31:0] operand_t;

   typedef logic [4:0] address_t;

   typedef struct packed {
      opcode_t  opc;
      operand_t op_a;
      operand_t op_b;
   } instruction_t;

   typedef enum logic {
      INIT,
      RUN
   } irs_state_t;

   // The largest register the address type can reach; also the default depth.
   localparam int IRS_MAX_DEPTH = 2 ** $bits(address_t);

   // Advance an address, wrapping to zero after depth-1 so that depths smaller
   // than the address range still behave as a circular buffer.
   function automatic address_t irsNextAddr(input address_t addr, input int unsigned depth);
      if (addr == address_t'(depth - 1)) begin
         return '0;
      end
      return addr + 1'b1;
   endfunction

endpackage

// File: rtl/instr_reg_scheduler_arbiter.sv
// -----------------------------------------------------------------------------
// irs_arbiter
// Two-way write-port arbiter for the instruction-register scheduler.
// Ports:
//   clk      in   clock, posedge
//   reset    in   synchronous active-high reset (priority returns to req 0)
//   valid_i  in   [1:0] per-requester request
//   enable_i in   grant is allowed this cycle (RUN and not full)
//   grant_o  out  [1:0] one-hot grant, all-zero when enable_i is low
// Build option:
//   IRS_ROUND_ROBIN_EN  defined   -> priority passes to the other requester
//                                   after every accept
//                       undefined -> requester 0 always holds priority
// -----------------------------------------------------------------------------
module irs_arbiter (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] valid_i,
   input  logic       enable_i,
   output logic [1:0] grant_o
);

   logic prio_q;
   logic prio_d;
   logic sel;

   // A lone requester wins outright; with both or neither valid the priority
   // holder is selected, so exactly one grant bit is high whenever enabled.
   always_comb begin
      sel = prio_q;
      if (valid_i == 2'b01) begin
         sel = 1'b0;
      end else if (valid_i == 2'b10) begin
         sel = 1'b1;
      end
      grant_o = 2'b00;
      if (enable_i) begin
         grant_o = sel ? 2'b10 : 2'b01;
      end
   end

   // Priority update. In fixed-priority builds the register is pinned to
   // requester 0, which folds away to a constant.
   always_comb begin
`ifdef IRS_ROUND_ROBIN_EN
      prio_d = prio_q;
      if (enable_i && valid_i[sel]) begin
         prio_d = ~sel;
      end
`else
      prio_d = 1'b0;
`endif
   end

   // Priority register.
   always_ff @(posedge clk) begin
      if (reset) begin
         prio_q <= 1'b0;
      end else begin
         prio_q <= prio_d;
      end
   end

endmodule

// File: rtl/instr_reg_scheduler.sv
// -----------------------------------------------------------------------------
// instr_reg_scheduler
// Shares the instruction register's single write port between two requesters
// and walks its read pointer as a FIFO, tracking occupancy so no unconsumed
// entry is ever overwritten.
// Parameters:
//   DEPTH        number of register entries (power of 2, <= address range)
//   INIT_CYCLES  cycles the register's reset_n is held low after reset
// Ports:
//   clk, reset                    clock and synchronous active-high reset
//   req_valid / req_ready [1:0]   per-requester handshake (valid && ready)
//   req0_* / req1_*               requester opcode and operands
//   reset_n                       active-low reset to the register
//   load_en                       one-cycle write strobe
//   opcode, operand_a, operand_b  registered write data
//   write_pointer, read_pointer   register addresses
//   rd_valid / rd_pop             read side: entry ready / consume it
//   count                         committed, unconsumed entries
// Build option: IRS_ROUND_ROBIN_EN selects round-robin arbitration inside
// irs_arbiter; default is fixed priority to requester 0.
// -----------------------------------------------------------------------------
module instr_reg_scheduler
   import instr_register_pkg::*;
#(
   parameter int DEPTH       = IRS_MAX_DEPTH,
   parameter int INIT_CYCLES = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [1:0]             req_valid,
   output logic [1:0]             req_ready,
   input  opcode_t                req0_opcode,
   input  operand_t               req0_operand_a,
   input  operand_t               req0_operand_b,
   input  opcode_t                req1_opcode,
   input  operand_t               req1_operand_a,
   input  operand_t               req1_operand_b,
   output logic                   reset_n,
   output logic                   load_en,
   output opcode_t                opcode,
   output operand_t               operand_a,
   output operand_t               operand_b,
   output address_t               write_pointer,
   output address_t               read_pointer,
   output logic                   rd_valid,
   input  logic                   rd_pop,
   output logic [$clog2(DEPTH):0] count
);

   localparam int CW  = $clog2(DEPTH) + 1;
   localparam int ICW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;

   irs_state_t   state_q;
   logic [ICW-1:0] initCnt_q;

   logic         loadEn_q,       loadEn_d;
   address_t     writePointer_q, writePointer_d;
   address_t     wrAddr_q,       wrAddr_d;
   address_t     rdPtr_q,        rdPtr_d;
   logic [CW-1:0] count_q,       count_d;
   instruction_t instr_q,        instr_d;

   logic [CW-1:0] occ;
   logic          full;
   logic          grantEnable;
   logic          accept;
   logic          rdValid;
   logic          pop;

   // Start-up sequencer: hold the register in reset for INIT_CYCLES cycles,
   // then open the write port for good until the next reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= INIT;
         initCnt_q <= '0;
      end else if (state_q == INIT) begin
         if (initCnt_q == ICW'(INIT_CYCLES - 1)) begin
            state_q <= RUN;
         end else begin
            initCnt_q <= initCnt_q + 1'b1;
         end
      end
   end

   // A write still in flight already owns its slot, so it counts toward
   // occupancy; otherwise a grant could be issued one entry too many.
   always_comb begin
      occ         = count_q + CW'(loadEn_q);
      full        = (occ == CW'(DEPTH));
      grantEnable = (state_q == RUN) && !full;
   end

   irs_arbiter u_arbiter (
      .clk      (clk),
      .reset    (reset),
      .valid_i  (req_valid),
      .enable_i (grantEnable),
      .grant_o  (req_ready)
   );

   // Handshake and read-side qualifiers. A pop of an empty FIFO is masked so
   // the read pointer and count can never underflow.
   always_comb begin
      accept  = |(req_valid & req_ready);
      rdValid = (state_q == RUN) && (count_q != '0);
      pop     = rd_pop && rdValid;
   end

   // Next-state for the datapath: accept latches data and reserves the next
   // write address; a completed load_en commits; a pop frees the head entry.
   always_comb begin
      loadEn_d       = 1'b0;
      writePointer_d = writePointer_q;
      wrAddr_d       = wrAddr_q;
      instr_d        = instr_q;
      rdPtr_d        = rdPtr_q;
      count_d        = count_q;

      if (accept) begin
         loadEn_d       = 1'b1;
         writePointer_d = wrAddr_q;
         wrAddr_d       = irsNextAddr(wrAddr_q, DEPTH);
         if (req_ready[1]) begin
            instr_d = '{opc: req1_opcode, op_a: req1_operand_a, op_b: req1_operand_b};
         end else begin
            instr_d = '{opc: req0_opcode, op_a: req0_operand_a, op_b: req0_operand_b};
         end
      end

      if (pop) begin
         rdPtr_d = irsNextAddr(rdPtr_q, DEPTH);
      end

      case ({loadEn_q, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Datapath registers. Reset drops any in-flight write and clears both
   // pointers, the count and the latched data.
   always_ff @(posedge clk) begin
      if (reset) begin
         loadEn_q       <= 1'b0;
         writePointer_q <= '0;
         wrAddr_q       <= '0;
         rdPtr_q        <= '0;
         count_q        <= '0;
         instr_q        <= '0;
      end else begin
         loadEn_q       <= loadEn_d;
         writePointer_q <= writePointer_d;
         wrAddr_q       <= wrAddr_d;
         rdPtr_q        <= rdPtr_d;
         count_q        <= count_d;
         instr_q        <= instr_d;
      end
   end

   // Output mapping; everything on the write side comes straight from flops.
   always_comb begin
      reset_n       = (state_q == RUN);
      load_en       = loadEn_q;
      opcode        = instr_q.opc;
      operand_a     = instr_q.op_a;
      operand_b     = instr_q.op_b;
      write_pointer = writePointer_q;
      read_pointer  = rdPtr_q;
      rd_valid      = rdValid;
      count         = count_q;
   end

endmodule

// File: tb/tb_instr_reg_scheduler.sv
// -----------------------------------------------------------------------------
// tb_instr_reg_scheduler
// Directed bench for instr_reg_scheduler at default parameters (DEPTH 32,
// INIT_CYCLES 2). Expected values are hand-derived cycle by cycle. Arbitration
// expectations follow IRS_ROUND_ROBIN_EN when the bench is built with it.
// -----------------------------------------------------------------------------
module tb_instr_reg_scheduler;
   import instr_register_pkg::*;

   logic        clk;
   logic        reset;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   opcode_t     req0_opcode;
   operand_t    req0_operand_a;
   operand_t    req0_operand_b;
   opcode_t     req1_opcode;
   operand_t    req1_operand_a;
   operand_t    req1_operand_b;
   logic        reset_n;
   logic        load_en;
   opcode_t     opcode;
   operand_t    operand_a;
   operand_t    operand_b;
   address_t    write_pointer;
   address_t    read_pointer;
   logic        rd_valid;
   logic        rd_pop;
   logic [5:0]  count;

   int compared   = 0;
   int mismatched = 0;

   instr_reg_scheduler dut (
      .clk            (clk),
      .reset          (reset),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req0_opcode    (req0_opcode),
      .req0_operand_a (req0_operand_a),
      .req0_operand_b (req0_operand_b),
      .req1_opcode    (req1_opcode),
      .req1_operand_a (req1_operand_a),
      .req1_operand_b (req1_operand_b),
      .reset_n        (reset_n),
      .load_en        (load_en),
      .opcode         (opcode),
      .operand_a      (operand_a),
      .operand_b      (operand_b),
      .write_pointer  (write_pointer),
      .read_pointer   (read_pointer),
      .rd_valid       (rd_valid),
      .rd_pop         (rd_pop),
      .count          (count)
   );

   // 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case the sequence ever stalls.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed=timeout expected=sequence complete");
      $fatal(1, "[TB] watchdog expired");
   end

   // Advance past the next rising edge so registered outputs have settled.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive the handshake inputs and let combinational outputs settle.
   task automatic applyStimulus(input logic [1:0] valid, input logic pop);
      req_valid = valid;
      rd_pop    = pop;
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, " reset_n"},   64'(reset_n),       64'd0);
      checkOutput({tag, " load_en"},   64'(load_en),       64'd0);
      checkOutput({tag, " opcode"},    64'(opcode),        64'd0);
      checkOutput({tag, " operand_a"}, 64'(operand_a),     64'd0);
      checkOutput({tag, " operand_b"}, 64'(operand_b),     64'd0);
      checkOutput({tag, " wp"},        64'(write_pointer), 64'd0);
      checkOutput({tag, " rp"},        64'(read_pointer),  64'd0);
      checkOutput({tag, " count"},     64'(count),         64'd0);
      checkOutput({tag, " rd_valid"},  64'(rd_valid),      64'd0);
      checkOutput({tag, " req_ready"}, 64'(req_ready),     64'd0);
   endtask

   logic [1:0] expGrant [4];
   opcode_t    expOpc   [4];

   initial begin
      reset          = 1'b1;
      req_valid      = 2'b00;
      rd_pop         = 1'b0;
      req0_opcode    = ZERO;
      req0_operand_a = '0;
      req0_operand_b = '0;
      req1_opcode    = ZERO;
      req1_operand_a = '0;
      req1_operand_b = '0;

`ifdef IRS_ROUND_ROBIN_EN
      expGrant = '{2'b01, 2'b10, 2'b01, 2'b10};
      expOpc   = '{SUB, MULT, SUB, MULT};
`else
      expGrant = '{2'b01, 2'b01, 2'b01, 2'b01};
      expOpc   = '{SUB, SUB, SUB, SUB};
`endif

      // Power-on reset.
      tick();
      tick();
      checkResetValues("por");

      // Release reset; req0 waits with ADD 5,3 through the INIT window.
      reset          = 1'b0;
      req0_opcode    = ADD;
      req0_operand_a = 32'sd5;
      req0_operand_b = 32'sd3;
      applyStimulus(2'b01, 1'b0);
      checkOutput("init c1 reset_n", 64'(reset_n), 64'd0);
      checkOutput("init c1 ready", 64'(req_ready), 64'd0);
      tick();
      checkOutput("init c2 reset_n", 64'(reset_n), 64'd0);
      checkOutput("init c2 ready", 64'(req_ready), 64'd0);
      tick();
      checkOutput("run reset_n", 64'(reset_n), 64'd1);
      checkOutput("run ready", 64'(req_ready), 64'd1);

      // Single write: accept on this edge, load_en the cycle after.
      tick();
      checkOutput("single load_en", 64'(load_en), 64'd1);
      checkOutput("single wp", 64'(write_pointer), 64'd0);
      checkOutput("single opcode", 64'(opcode), 64'(ADD));
      checkOutput("single a", 64'(operand_a), 64'd5);
      checkOutput("single b", 64'(operand_b), 64'd3);
      checkOutput("single count pre", 64'(count), 64'd0);
      checkOutput("single rd_valid pre", 64'(rd_valid), 64'd0);
      applyStimulus(2'b00, 1'b0);
      checkOutput("idle ready holder", 64'(req_ready), 64'd1);
      tick();
      checkOutput("single load_en off", 64'(load_en), 64'd0);
      checkOutput("single count", 64'(count), 64'd1);
      checkOutput("single rd_valid", 64'(rd_valid), 64'd1);

      // Lone req1 is granted even though req0 holds priority.
      req1_opcode    = PASSA;
      req1_operand_a = 32'sd7;
      req1_operand_b = 32'sd9;
      applyStimulus(2'b10, 1'b0);
      checkOutput("req1 alone ready", 64'(req_ready), 64'd2);
      tick();
      checkOutput("req1 wp", 64'(write_pointer), 64'd1);
      checkOutput("req1 opcode", 64'(opcode), 64'(PASSA));
      checkOutput("req1 a", 64'(operand_a), 64'd7);

      // Contention for four back-to-back cycles.
      req0_opcode    = SUB;
      req0_operand_a = 32'sd11;
      req0_operand_b = 32'sd12;
      req1_opcode    = MULT;
      req1_operand_a = 32'sd21;
      req1_operand_b = 32'sd22;
      applyStimulus(2'b11, 1'b0);
      for (int k = 0; k < 4; k++) begin
         checkOutput($sformatf("contend ready %0d", k), 64'(req_ready), 64'(expGrant[k]));
         tick();
         checkOutput($sformatf("contend load_en %0d", k), 64'(load_en), 64'd1);
         checkOutput($sformatf("contend wp %0d", k), 64'(write_pointer), 64'(2 + k));
         checkOutput($sformatf("contend opcode %0d", k), 64'(opcode), 64'(expOpc[k]));
      end
      checkOutput("contend count", 64'(count), 64'd5);

      // Reset for three cycles with count 5 and a write still pending.
      reset = 1'b1;
      applyStimulus(2'b01, 1'b0);
      tick();
      checkResetValues("midrst");
      tick();
      tick();
      reset = 1'b0;
      #1;
      checkOutput("rel c1 reset_n", 64'(reset_n), 64'd0);
      checkOutput("rel c1 ready", 64'(req_ready), 64'd0);
      tick();
      checkOutput("rel c2 reset_n", 64'(reset_n), 64'd0);
      checkOutput("rel c2 ready", 64'(req_ready), 64'd0);
      tick();
      checkOutput("rel c3 ready", 64'(req_ready), 64'd1);

      // Four accepts to addresses 0..3; entry 3 commits alongside a pop.
      for (int k = 0; k < 4; k++) begin
         tick();
         checkOutput($sformatf("fill wp %0d", k), 64'(write_pointer), 64'(k));
      end
      checkOutput("simul count pre", 64'(count), 64'd3);
      checkOutput("simul load_en pre", 64'(load_en), 64'd1);
      applyStimulus(2'b01, 1'b1);
      tick();
      checkOutput("simul count", 64'(count), 64'd3);
      checkOutput("simul rp", 64'(read_pointer), 64'd1);
      checkOutput("simul wp", 64'(write_pointer), 64'd4);
      applyStimulus(2'b00, 1'b0);
      tick();
      checkOutput("simul commit", 64'(count), 64'd4);

      // Drain, then pop an empty FIFO.
      applyStimulus(2'b00, 1'b1);
      for (int k = 0; k < 4; k++) begin
         tick();
      end
      checkOutput("drain count", 64'(count), 64'd0);
      checkOutput("drain rp", 64'(read_pointer), 64'd5);
      checkOutput("drain rd_valid", 64'(rd_valid), 64'd0);
      tick();
      tick();
      checkOutput("empty pop rp", 64'(read_pointer), 64'd5);
      checkOutput("empty pop count", 64'(count), 64'd0);

      // Fresh start for the full / wrap test.
      applyStimulus(2'b00, 1'b0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
      tick();
      req0_opcode = MOD;
      applyStimulus(2'b01, 1'b0);
      for (int k = 0; k < 32; k++) begin
         checkOutput($sformatf("full ready %0d", k), 64'(req_ready), 64'd1);
         tick();
      end
      checkOutput("full wp last", 64'(write_pointer), 64'd31);
      checkOutput("full ready occ32", 64'(req_ready), 64'd0);
      checkOutput("full count pre", 64'(count), 64'd31);
      tick();
      checkOutput("full count", 64'(count), 64'd32);
      checkOutput("full ready held", 64'(req_ready), 64'd0);
      applyStimulus(2'b01, 1'b1);
      checkOutput("full ready with pop", 64'(req_ready), 64'd0);
      tick();
      checkOutput("full pop count", 64'(count), 64'd31);
      checkOutput("full pop rp", 64'(read_pointer), 64'd1);
      applyStimulus(2'b01, 1'b0);
      checkOutput("full reopen ready", 64'(req_ready), 64'd1);
      tick();
      checkOutput("wrap wp", 64'(write_pointer), 64'd0);
      checkOutput("wrap load_en", 64'(load_en), 64'd1);
      applyStimulus(2'b00, 1'b0);
      tick();
      checkOutput("wrap count", 64'(count), 64'd32);
      checkOutput("wrap ready", 64'(req_ready), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
